divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port: clock  in  1  rising-edge system clock.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset, sampled on rising clock.
REQ-003 SHALL have port: start  in  1  level input; a 0->1 transition requests one division.
REQ-004 SHALL have port: a  in  16  dividend, sampled on the accepted start edge.
REQ-005 SHALL have port: b  in  8  divisor, sampled on the accepted start edge.
REQ-006 SHALL have port: quotient  out  16  unsigned a/b, valid while ready=1.
REQ-007 SHALL have port: remainder  out  8  unsigned a mod b, valid while ready=1.
REQ-008 SHALL have port: busy  out  1  high while a division is in progress.
REQ-009 SHALL have port: ready  out  1  high from completion until the next accepted start.
REQ-010 SHALL have port, only when DIVIDER_DIVZERO_EN is defined: div_zero  out  1  last accepted divisor was zero.

Function
REQ-011 SHALL register start every cycle as start_q; accepted start = start & ~start_q & ~busy.
REQ-012 SHALL ignore start edges while busy=1; start held high SHALL NOT retrigger.
REQ-013 SHALL implement states IDLE and CALC: IDLE->CALC on accepted start; CALC->IDLE after the 16th iteration.
REQ-014 On accepted start: latch a, b; clear partial remainder (9 bits) and 5-bit counter; ready<=0; busy<=1.
REQ-015 Each CALC cycle SHALL do one restoring step, MSB first: t = {rem[7:0], dividend_msb} - {1'b0, b}; if no borrow, rem<=t and quotient bit=1, else rem unchanged-shifted and bit=0.
REQ-016 Dividend/quotient SHALL share one 16-bit shift register, left-shifted one bit per iteration.
REQ-017 Exactly one trial subtraction per clock; latency from accepted-start cycle N to ready=1 SHALL be cycle N+17.
REQ-018 At completion: busy<=0, ready<=1; quotient/remainder SHALL hold until the next accepted start.
REQ-019 Start edge arriving in the same cycle that ready is set SHALL be ignored (busy still 1 that cycle).
REQ-020 b=0 without DIVIDER_DIVZERO_EN: algorithm runs unchanged; result quotient=0xFFFF, remainder=a[7:0], latency 17.

Reset
REQ-021 reset=0 SHALL force IDLE, busy=0, ready=0, quotient=0, remainder=0, counter=0, start_q=0 (and div_zero=0), overriding start in the same cycle.
REQ-022 reset asserted mid-CALC SHALL abort the division; no ready pulse SHALL follow.

Configuration
REQ-023 Macro DIVIDER_DIVZERO_EN defined: b=0 on accepted start SHALL skip CALC, set quotient=0xFFFF, remainder=a[7:0], div_zero=1, ready=1 at cycle N+1; div_zero cleared on next accepted start.
REQ-024 Macro undefined: no div_zero port, no early exit; REQ-020 applies.

Structure
REQ-025 Package div_pkg SHALL hold DIVIDEND_W=16, DIVISOR_W=8, CNT_W=5, ITER=16, state encodings IDLE/CALC.
REQ-026 Sub-module divider_sub9 SHALL compute the 9-bit trial subtraction as a ripple of full_summator cells (a + ~b, cin=1), exporting difference and no-borrow.

Verification
REQ-027 a=0x03E8, b=0x07, start 0->1 -> busy 16 cycles, ready at N+17, quotient=0x008E, remainder=0x06.
REQ-028 a=0xFFFF, b=0xFF -> quotient=0x0101, remainder=0x00; a=0x0005, b=0x09 -> quotient=0x0000, remainder=0x05.
REQ-029 a=0x1234, b=0x00 -> quotient=0xFFFF, remainder=0x34; ready at N+17 (macro off) or N+1 with div_zero=1 (macro on).
REQ-030 start held high 40 cycles after first edge -> exactly one division; second 0->1 edge during busy -> ignored, results unchanged.
REQ-031 reset=0 at iteration 8 -> next cycle busy=0, ready=0, outputs 0; fresh start a=0x0064, b=0x0A -> quotient=0x000A, remainder=0x00.

Source files
------------

// File: rtl/div_pkg.sv
// Shared widths, iteration count and FSM encodings for the divider.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = 5;
    localparam int ITER       = 16;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle of the divider.
// div_zero exists only when DIVIDER_DIVZERO_EN is defined.
interface divider_if;
    import div_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] a;
    logic [DIVISOR_W-1:0]  b;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  busy;
    logic                  ready;
`ifdef DIVIDER_DIVZERO_EN
    logic                  div_zero;

    modport master (
        output start, a, b,
        input  quotient, remainder, busy, ready, div_zero
    );
    modport slave (
        input  start, a, b,
        output quotient, remainder, busy, ready, div_zero
    );
`else
    modport master (
        output start, a, b,
        input  quotient, remainder, busy, ready
    );
    modport slave (
        input  start, a, b,
        output quotient, remainder, busy, ready
    );
`endif

endinterface

// File: rtl/divider_sub9.sv
// 9-bit ripple subtractor a - b computed as a + ~b + 1.
// no_borrow_o is the final carry: high when a >= b.
module divider_sub9 (
    input  logic [8:0] a_i,
    input  logic [8:0] b_i,
    output logic [8:0] diff_o,
    output logic       no_borrow_o
);

    logic [9:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < 9; i++) begin : g_cell
        full_summator u_fs (
            .a    (a_i[i]),
            .b    (~b_i[i]),
            .cin  (carry[i]),
            .s    (diff_o[i]),
            .cout (carry[i+1])
        );
    end

    assign no_borrow_o = carry[9];

endmodule

// File: rtl/full_summator.sv
// One-bit full adder cell.
module full_summator (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/divider.sv
// 16/8 unsigned restoring divider, one trial subtraction per clock.
// Define DIVIDER_DIVZERO_EN for a one-cycle divide-by-zero exit and div_zero flag.
module divider
    import div_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    divider_if.slave bus
);

    logic [0:0]            state_q, state_d;
    logic                  start_q;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
`ifdef DIVIDER_DIVZERO_EN
    logic                  dz_q, dz_d;
`endif

    logic               busy;
    logic               accept;
    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] diff;
    logic               no_borrow;
    logic               unused_rem_msb;

    assign busy   = (state_q == CALC);
    assign accept = bus.start & ~start_q & ~busy;
    // dividend and quotient share dvd_q: MSB feeds the trial, LSB takes the bit
    assign trial  = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};

    divider_sub9 u_sub9 (
        .a_i         (trial),
        .b_i         ({1'b0, dsr_q}),
        .diff_o      (diff),
        .no_borrow_o (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
`ifdef DIVIDER_DIVZERO_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d   = bus.a;
                    dsr_d   = bus.b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = CALC;
`ifdef DIVIDER_DIVZERO_EN
                    dz_d    = (bus.b == '0);
                    if (bus.b == '0) begin
                        dvd_d   = '1;
                        rem_d   = {1'b0, bus.a[DIVISOR_W-1:0]};
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
            CALC: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], no_borrow};
                rem_d = no_borrow ? diff : trial;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
`ifdef DIVIDER_DIVZERO_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
`ifdef DIVIDER_DIVZERO_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign unused_rem_msb = rem_q[DIVISOR_W];
    assign bus.quotient   = dvd_q;
    assign bus.remainder  = rem_q[DIVISOR_W-1:0];
    assign bus.busy       = busy;
    assign bus.ready      = ready_q;
`ifdef DIVIDER_DIVZERO_EN
    assign bus.div_zero   = dz_q;
`endif

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the divider: launches divisions, checks latency,
// busy length and results, plus reset, abort and ignored-edge scenarios.
module tb_divider;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        int          lat;
        int          bz;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    divider_if bus ();

    divider u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic launch(input logic [15:0] av, input logic [7:0] bv,
                          input bit push);
        exp_t e;
        if (bv == 8'h00) begin
            e.q = 16'hFFFF;
            e.r = av[7:0];
        end else begin
            e.q = av / {8'h00, bv};
            e.r = 8'(av % {8'h00, bv});
        end
`ifdef DIVIDER_DIVZERO_EN
        e.lat = (bv == 8'h00) ? 1 : 17;
        e.bz  = (bv == 8'h00) ? 0 : 16;
`else
        e.lat = 17;
        e.bz  = 16;
`endif
        e.dz = (bv == 8'h00);
        if (push) sb.push_back(e);
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
    endtask

    task automatic await_result(input string name, input int toggle_at);
        int   k;
        int   bcnt;
        bit   got;
        exp_t e;
        k    = 0;
        bcnt = 0;
        got  = 1'b0;
        while (!got && k < 40) begin
            @(negedge clock);
            k++;
            if (bus.busy === 1'b1) bcnt++;
            if (bus.ready === 1'b1) got = 1'b1;
            else if (toggle_at > 0 && k == toggle_at) bus.start = 1'b0;
            else if (toggle_at > 0 && k == toggle_at + 1) bus.start = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: ready=%b after %0d cycles, want 1", name, bus.ready, k);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty: got 0 entries, want 1", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (k !== e.lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, k, e.lat);
        end
        checks++;
        if (bcnt !== e.bz) begin
            errors++;
            $display("FAIL %s busy cycles got %0d want %0d", name, bcnt, e.bz);
        end
        checks++;
        if (bus.quotient !== e.q) begin
            errors++;
            $display("FAIL %s quotient got %h want %h", name, bus.quotient, e.q);
        end
        checks++;
        if (bus.remainder !== e.r) begin
            errors++;
            $display("FAIL %s remainder got %h want %h", name, bus.remainder, e.r);
        end
`ifdef DIVIDER_DIVZERO_EN
        checks++;
        if (bus.div_zero !== e.dz) begin
            errors++;
            $display("FAIL %s div_zero got %b want %b", name, bus.div_zero, e.dz);
        end
`endif
    endtask

    task automatic check_hold(input string name, input int n,
                              input logic [15:0] q, input logic [7:0] r);
        bit ok;
        ok = 1'b1;
        repeat (n) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.ready !== 1'b1 ||
                bus.quotient !== q || bus.remainder !== r) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s hold busy=%b ready=%b q=%h r=%h want 0 1 %h %h",
                     name, bus.busy, bus.ready, bus.quotient, bus.remainder, q, r);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 8'h03;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy got %b want 0", bus.busy);
        end
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset ready got %b want 0", bus.ready);
        end
        checks++;
        if (bus.quotient !== 16'h0000) begin
            errors++;
            $display("FAIL reset quotient got %h want 0000", bus.quotient);
        end
        checks++;
        if (bus.remainder !== 8'h00) begin
            errors++;
            $display("FAIL reset remainder got %h want 00", bus.remainder);
        end
`ifdef DIVIDER_DIVZERO_EN
        checks++;
        if (bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset div_zero got %b want 0", bus.div_zero);
        end
`endif
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [15:0] av[3];
        logic [7:0]  bv[3];
        av = '{16'h03E8, 16'hFFFF, 16'h0005};
        bv = '{8'h07,    8'hFF,    8'h09};
        for (int i = 0; i < 3; i++) begin
            launch(av[i], bv[i], 1'b1);
            await_result($sformatf("basic%0d", i), -1);
        end
        for (int i = 0; i < 4; i++) begin
            launch(16'($urandom), 8'($urandom_range(1, 255)), 1'b1);
            await_result($sformatf("rand%0d", i), -1);
        end
    endtask

    task automatic test_div_zero();
        launch(16'h1234, 8'h00, 1'b1);
        await_result("div_zero", -1);
        launch(16'h0064, 8'h05, 1'b1);
        await_result("after_div_zero", -1);
    endtask

    task automatic test_held_start();
        logic [15:0] q;
        logic [7:0]  r;
        q = 16'hBEEF / 16'h002D;
        r = 8'(16'hBEEF % 16'h002D);
        launch(16'hBEEF, 8'h2D, 1'b1);
        await_result("held", -1);
        check_hold("held", 23, q, r);
        bus.start = 1'b0;
    endtask

    task automatic test_ignored_edge();
        logic [15:0] q;
        logic [7:0]  r;
        q = 16'h7531 / 16'h000C;
        r = 8'(16'h7531 % 16'h000C);
        launch(16'h7531, 8'h0C, 1'b1);
        await_result("edge_busy", 5);
        check_hold("edge_busy", 5, q, r);
        launch(16'h0400, 8'h20, 1'b1);
        await_result("edge_at_done", 15);
        check_hold("edge_at_done", 5, 16'h0020, 8'h00);
    endtask

    task automatic test_abort();
        bit ok;
        launch(16'hABCD, 8'h13, 1'b0);
        repeat (8) @(negedge clock);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL abort flags busy=%b ready=%b want 0 0", bus.busy, bus.ready);
        end
        checks++;
        if (bus.quotient !== 16'h0000 || bus.remainder !== 8'h00) begin
            errors++;
            $display("FAIL abort outputs q=%h r=%h want 0000 00", bus.quotient, bus.remainder);
        end
        reset = 1'b1;
        ok    = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (bus.ready !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort quiet ready=%b busy=%b want 0 0", bus.ready, bus.busy);
        end
        launch(16'h0064, 8'h0A, 1'b1);
        await_result("abort_fresh", -1);
        bus.start = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_held_start();
        test_ignored_edge();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
